// File: rtl/alu_sequencer_if.sv
// Bundles the instruction handshake, the ireg ports, the ALU ports and the external write port.
// The sequencer uses the slave modport; the front end, ireg and ALU side uses master.
interface alu_sequencer_if;
    logic        start;
    logic [3:0]  op;
    logic [5:0]  ra;
    logic [5:0]  rb;
    logic [5:0]  rd;
    logic        ready;
    logic        done;
    logic        err;
    logic [5:0]  r0;
    logic [5:0]  r1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [5:0]  rw;
    logic [31:0] dw;
    logic        we;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_dout;
    logic        ext_req;
    logic [5:0]  ext_rw;
    logic [31:0] ext_dw;
    logic        ext_gnt;

    modport slave (
        input  start, op, ra, rb, rd, d0, d1, alu_dout, ext_req, ext_rw, ext_dw,
        output ready, done, err, r0, r1, rw, dw, we, alu_op, alu_a, alu_b, ext_gnt
    );

    modport master (
        output start, op, ra, rb, rd, d0, d1, alu_dout, ext_req, ext_rw, ext_dw,
        input  ready, done, err, r0, r1, rw, dw, we, alu_op, alu_a, alu_b, ext_gnt
    );
endinterface

// File: rtl/alu_sequencer.sv
// Single-issue rd = ra op rb controller: read operands, run the ALU for an op-dependent count, write back.
// Done arrives L+2 cycles after accept (2 on error); ireg write port is shared, WB beats external requests.
module alu_sequencer #(
    parameter int LAT_MUL = 3,
    parameter int LAT_DIV = 8
) (
    input  logic            clk,
    input  logic            reset,
    alu_sequencer_if.slave  io
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_EXEC = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [5:0]  ra_q, ra_d;
    logic [5:0]  rb_q, rb_d;
    logic [5:0]  rd_q, rd_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_q, res_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        op_legal;
    logic        op_div;

    always_comb begin
        op_legal = 1'b0;
        case (op_q)
            4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
        op_div = (op_q == 4'hA) || (op_q == 4'hB);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    op_d    = io.op;
                    ra_d    = io.ra;
                    rb_d    = io.rb;
                    rd_d    = io.rd;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                a_d = io.d0;
                b_d = io.d1;
                if (!op_legal || (op_div && io.d1 == 32'd0)) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_EXEC;
                    if (op_q == 4'h6)  cnt_d = 8'(LAT_MUL);
                    else if (op_div)   cnt_d = 8'(LAT_DIV);
                    else               cnt_d = 8'd1;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    res_d   = io.alu_dout;
                    state_d = S_WB;
                end
            end
            S_WB:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 4'd0;
            ra_q    <= 6'd0;
            rb_q    <= 6'd0;
            rd_q    <= 6'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            res_q   <= 32'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read addresses and ALU inputs come straight from the latched fields, so they hold through EXEC.
    assign io.r0     = ra_q;
    assign io.r1     = rb_q;
    assign io.alu_op = op_q;
    assign io.alu_a  = a_q;
    assign io.alu_b  = b_q;
    assign io.ready  = (state_q == S_IDLE);
    assign io.done   = (state_q == S_WB) || (state_q == S_ERR);
    assign io.err    = (state_q == S_ERR);

    // The reset term keeps the grant low while reset is held, independent of the state register.
    assign io.ext_gnt = io.ext_req && (state_q != S_WB) && !reset;

    always_comb begin
        io.we = 1'b0;
        io.rw = 6'd0;
        io.dw = 32'd0;
        if (state_q == S_WB) begin
            io.we = 1'b1;
            io.rw = rd_q;
            io.dw = res_q;
        end else if (io.ext_gnt) begin
            io.we = 1'b1;
            io.rw = io.ext_rw;
            io.dw = io.ext_dw;
        end
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Single-issue controller that executes one register-to-register ALU instruction, rd = ra op rb. It sits between the integer register file (ireg), the ALU (ALUController) and the instruction front end. It reads both operands from ireg, drives the ALU, and waits an op-dependent latency. It then writes the result back, sharing the ireg write port with an external load requester.

Parameters:
LAT_MUL, 3, EXEC cycles for op 6 (MUL); legal range 1..255
LAT_DIV, 8, EXEC cycles for ops A/B (DIV/MOD); legal range 1..255

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  instruction request
op  in  4  ALU opcode (0 OR, 1 XOR, 2 AND, 4 ADD, 5 SUB, 6 MUL, 8 SHL, 9 SAR, A DIV, B MOD)
ra, rb, rd  in  6  source A, source B, destination register
ready  out  1  able to accept start
done  out  1  one-cycle completion pulse
err  out  1  qualifies done: illegal op or divide by zero
r0, r1  out  6  ireg read addresses
d0, d1  in  32  ireg read data (combinational from r0/r1)
rw  out  6  ireg write address
dw  out  32  ireg write data
we  out  1  ireg write enable
alu_op  out  4  to ALU
alu_a, alu_b  out  32  ALU operands
alu_dout  in  32  ALU result (combinational)
ext_req  in  1  external write request
ext_rw  in  6  external write address
ext_dw  in  32  external write data
ext_gnt  out  1  external write accepted this cycle

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high.
- FSM states: IDLE, READ, EXEC, WB, ERR. Reset forces IDLE. All registers clear to 0. No instruction is in flight after reset.
- Reset values: done=0, err=0, we=0, ext_gnt=0. ready=1 (IDLE). r0, r1, rw, dw, alu_op, alu_a and alu_b are all 0.
- ready = (state==IDLE). start is sampled only when ready=1. On that edge, op, ra, rb and rd are latched.
- IDLE -> READ on accept.
- READ: r0 = latched ra, r1 = latched rb. d0/d1 are latched into operand registers at the end of the cycle.
  - Illegal op (3, 7, C, D, E, F) -> ERR.
  - DIV or MOD with d1==0 -> ERR.
  - Otherwise -> EXEC, with cnt loaded as follows: LAT_MUL for MUL, LAT_DIV for DIV/MOD, 1 for all other ops.
- EXEC: alu_op, alu_a and alu_b are held from the latched values, stable for every EXEC cycle. cnt decrements each cycle. In the cycle where cnt==1, alu_dout is latched into the result register and the FSM goes to WB.
- WB, one cycle: we=1, rw=rd, dw=result, done=1, err=0. Then -> IDLE.
- ERR, one cycle: done=1, err=1, we=0 (no register modified). Then -> IDLE.
- Latency, counted from the accepting edge:
  - done is high in cycle L+2, where L is the EXEC count.
  - For ERR, done is high in cycle 2.
  - ready is high again in the cycle after done.
- No back-to-back overlap. start while ready=0 is ignored, not queued.
- Write-port arbitration, combinational:
  - ext_gnt = ext_req & (state != WB).
  - When ext_gnt=1: we=1, rw=ext_rw, dw=ext_dw.
  - WB always has priority. ext_req denied in WB must be held by the requester and is granted the next cycle.
- Hazards:
  - An external write to ra/rb in the READ cycle is not seen; the old value is read.
  - An external write to rd during EXEC is overwritten by WB.
  - An external write in IDLE to a register that the next accepted instruction reads is visible to it.
- Arithmetic: 32-bit. Result width and signedness are defined by the ALU. The sequencer does not modify alu_dout.
- Reset mid-operation aborts immediately: no done and no write. ext_gnt drops to 0 while reset is high.
- rd=ra or rd=rb is legal; operands are latched before WB.

Test Plan:
1. Preload R1=5, R2=7. start op=4, ra=1, rb=2, rd=3 -> done=1, err=0 in cycle 3 with we=1, rw=3, dw=12. R3 reads 12. ready=1 in cycle 4.
2. LAT_MUL=3, R1=6, R2=7, op=6, rd=4 -> alu_a/alu_b stable for 3 EXEC cycles. done in cycle 5, R4=42.
3. R1=9, R2=0, op=A -> done=1, err=1 in cycle 2. we never asserted. All registers unchanged.
4. op=4'hF -> done=1, err=1 in cycle 2, no write. A following ADD completes normally.
5. Hold ext_req=1 (ext_rw=10, ext_dw=32'hDEADBEEF) across an ADD -> ext_gnt=0 only in the WB cycle, otherwise 1. R10=32'hDEADBEEF. The ADD result is written correctly.
6. Assert reset during cycle 4 of a DIV with LAT_DIV=8 -> no done and no we. After reset deasserts, ready=1. The destination register keeps its old value.
